mips_ctrl_fsm: RTL and testbench
================================

# mips_ctrl_fsm

Multi-cycle control sequencer for the MIPS core. It fetches one instruction word at the current PC and decodes it. It sequences operand reads through the single-port register file, then drives the ALU and writes the result back. It also issues PC advance or branch-load commands. It sits between the PC/instruction source and the ALU/register-file datapath, and is the block that drives their control inputs.

## Interface
- WORD_SIZE, 32, datapath and instruction width
- OP_SIZE, 4, ALU select width
- CNT_SIZE, 16, retired-instruction counter width
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- step  input  1  level; while high, a new instruction starts from IDLE
- pc_counter  input  WORD_SIZE  current PC
- instr_req  output  1  fetch request, address = pc_counter
- instr_valid  input  1  instruction word valid
- instr  input  WORD_SIZE  instruction word
- reg_on, reg_w  output  1  register-file enable / write strobe
- reg_addr  output  WORD_SIZE  register index, upper bits zero
- reg_data_in  output  WORD_SIZE  write data
- reg_data_out  input  WORD_SIZE  read data, valid one cycle after reg_on=1 with reg_w=0
- data_1, data_2  output  WORD_SIZE  ALU operands
- sel  output  OP_SIZE  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- alu_out  input  WORD_SIZE  ALU result (combinational)
- alu_zero_flag  input  1  ALU result == 0
- pc_offset  output  1  one-cycle pulse: PC += 4
- load_pc  output  1  one-cycle pulse: PC = pc_data
- pc_data  output  WORD_SIZE  branch target
- instr_done  output  1  one-cycle pulse per retired instruction
- instr_count  output  CNT_SIZE  retired count, wraps to 0
- halted  output  1  sticky illegal-opcode flag

## Operation
- States: IDLE, FETCH, RD_RS, RD_RT, EXEC, WB, BR, HALT.
- IDLE: if step=1, go to FETCH next cycle.
- FETCH: instr_req=1 until instr_valid=1; the word is latched on that edge. Then:
  - opcode 0x00, 0x08 or 0x04 → RD_RS.
  - any other opcode, or R-type funct not in {0x20, 0x22, 0x24, 0x25, 0x2A} → HALT.
- RD_RS: reg_on=1, reg_addr=rs. Next state is RD_RT for R-type/BEQ and EXEC for ADDI.
- RD_RT: capture reg_data_out into A; reg_on=1, reg_addr=rt.
- EXEC: capture B (R-type/BEQ), or capture A (ADDI).
  - data_1=A; data_2=B for R-type/BEQ, or sign-extended imm[15:0] for ADDI.
  - sel from funct (0x20→0, 0x22→1, 0x24→2, 0x25→3, 0x2A→4); ADDI→0; BEQ→1.
  - Latch alu_out into R and alu_zero_flag into Z.
  - Next state is BR for BEQ, else WB.
- WB: reg_on=1, reg_w=1, reg_data_in=R, pc_offset=1, instr_done=1, then IDLE.
  - reg_addr is rd for R-type and rt for ADDI.
  - If the destination is 0, reg_on and reg_w stay 0; PC and done still fire.
- BR: instr_done=1, then IDLE.
  - Z=1: load_pc=1, pc_data = pc_counter + 4 + (sext(imm) << 2), modulo 2^WORD_SIZE.
  - Z=0: pc_offset=1.
- HALT: halted=1, all strobes 0; left only by reset.
- instr_count increments on every instr_done, wrapping from 2^CNT_SIZE-1 to 0.
- Outside their active states, data_1, data_2, sel, reg_addr and reg_data_in hold their last value.

## Timing
- Reset (rst=0, asynchronous): state IDLE, every output 0, A/B/R/Z/count cleared.
  - An in-flight instruction is discarded with no register write and no PC update.
  - Outputs are 0 while rst=0.
- Latency counted from the FETCH capture edge (step high in IDLE adds 1 cycle before FETCH):
  - R-type and BEQ: 4 cycles.
  - ADDI: 3 cycles.
  - With instr_valid in the first FETCH cycle: R-type 6 cycles IDLE→IDLE, ADDI 5.
- instr_valid is ignored while instr_req=0.
- instr_req stays high, without re-sampling pc_counter, until instr_valid arrives.
- Exactly one of pc_offset/load_pc pulses per retired instruction, never both.
- No PC command in HALT.
- If step stays high, instructions run back-to-back with one IDLE cycle between them.
- pc_counter must be stable from FETCH through BR.

## Test plan
- R-type ADD: preload r1=5, r2=7; instr 0x00221820 (add r3,r1,r2) with instr_valid on the first cycle.
  - Expect reg_w pulse with addr 3, data 12, together with pc_offset=1, instr_done=1, count=1.
  - 6 cycles IDLE→IDLE.
- ADDI negative immediate: r1=3; instr 0x2022FFFE (addi r2,r1,-2).
  - Expect write addr 2, data 1.
  - No RD_RT cycle; 5 cycles IDLE→IDLE.
- BEQ: pc_counter=0x100, r1=r2=9; instr 0x1022FFFC (beq r1,r2,-4).
  - Taken: load_pc=1, pc_data=0xF4, no pc_offset.
  - Repeat with r2=8: pc_offset=1, load_pc=0.
- Write to $0: add r0,r1,r2 → reg_w never asserted; pc_offset and instr_done still pulse.
- Fetch stall and illegal opcode:
  - instr_valid delayed 5 cycles: instr_req held for 5 cycles, then normal completion.
  - Opcode 0x3F: halted=1, no strobes for 20 cycles even with step=1; rst=0 clears halted.
- Reset mid-op and wrap:
  - Assert rst in EXEC: no write, no PC pulse, all outputs 0.
  - With CNT_SIZE=2, retire 4 instructions: count sequence 1, 2, 3, 0.

Source files
------------

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: fetches one instruction, reads operands through a
// single-port register file, drives the ALU, writes back and issues PC advance/branch commands.
module mips_ctrl_fsm #(
  parameter int WORD_SIZE = 32,
  parameter int OP_SIZE   = 4,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic [WORD_SIZE-1:0] pc_counter,
  output logic                 instr_req,
  input  logic                 instr_valid,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 reg_on,
  output logic                 reg_w,
  output logic [WORD_SIZE-1:0] reg_addr,
  output logic [WORD_SIZE-1:0] reg_data_in,
  input  logic [WORD_SIZE-1:0] reg_data_out,
  output logic [WORD_SIZE-1:0] data_1,
  output logic [WORD_SIZE-1:0] data_2,
  output logic [OP_SIZE-1:0]   sel,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_zero_flag,
  output logic                 pc_offset,
  output logic                 load_pc,
  output logic [WORD_SIZE-1:0] pc_data,
  output logic                 instr_done,
  output logic [CNT_SIZE-1:0]  instr_count,
  output logic                 halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD_RS, S_RD_RT, S_EXEC, S_WB, S_BR, S_HALT
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_SLT    = 6'h2A;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OPC_ADDI, OPC_BEQ: ok = 1'b1;
      OPC_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                      (fn == FN_OR)  || (fn == FN_SLT);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [OP_SIZE-1:0] alu_sel(input logic [5:0] op, input logic [5:0] fn);
    logic [OP_SIZE-1:0] s;
    s = '0;
    if (op == OPC_BEQ) begin
      s = OP_SIZE'(1);
    end else if (op == OPC_RTYPE) begin
      case (fn)
        FN_SUB:  s = OP_SIZE'(1);
        FN_AND:  s = OP_SIZE'(2);
        FN_OR:   s = OP_SIZE'(3);
        FN_SLT:  s = OP_SIZE'(4);
        default: s = '0;
      endcase
    end
    return s;
  endfunction

  function automatic logic [WORD_SIZE-1:0] sext16(input logic [15:0] imm);
    return {{(WORD_SIZE-16){imm[15]}}, imm};
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic [WORD_SIZE-1:0]   a_q, a_d;
  logic [WORD_SIZE-1:0]   r_q, r_d;
  logic                   z_q, z_d;
  logic [CNT_SIZE-1:0]    cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic [OP_SIZE-1:0]     sel_q, sel_d;
  logic [WORD_SIZE-1:0]   raddr_q, raddr_d, rdin_q, rdin_d, pcd_q, pcd_d;

  logic [5:0]             op_w, fn_w;
  logic [4:0]             rs_w, rt_w, rd_w, dest_w;
  logic                   is_addi_w, is_beq_w;

  assign op_w      = ir_q[31:26];
  assign rs_w      = ir_q[25:21];
  assign rt_w      = ir_q[20:16];
  assign rd_w      = ir_q[15:11];
  assign fn_w      = ir_q[5:0];
  assign is_addi_w = (op_w == OPC_ADDI);
  assign is_beq_w  = (op_w == OPC_BEQ);
  assign dest_w    = is_addi_w ? rt_w : rd_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      sel_q   <= '0;
      raddr_q <= '0;
      rdin_q  <= '0;
      pcd_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      r_q     <= r_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      sel_q   <= sel_d;
      raddr_q <= raddr_d;
      rdin_q  <= rdin_d;
      pcd_q   <= pcd_d;
    end
  end

  // ALU result capture kept apart so the ALU feedback path never loops through the FSM block.
  always_comb begin
    r_d = r_q;
    z_d = z_q;
    if (state_q == S_EXEC) begin
      r_d = alu_out;
      z_d = alu_zero_flag;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    sel_d      = sel_q;
    raddr_d    = raddr_q;
    rdin_d     = rdin_q;
    pcd_d      = pcd_q;
    instr_req  = 1'b0;
    reg_on     = 1'b0;
    reg_w      = 1'b0;
    pc_offset  = 1'b0;
    load_pc    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step) state_d = S_FETCH;
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr[31:0];
          state_d = is_legal(instr[31:26], instr[5:0]) ? S_RD_RS : S_HALT;
        end
      end
      S_RD_RS: begin
        reg_on  = 1'b1;
        raddr_d = WORD_SIZE'(rs_w);
        state_d = is_addi_w ? S_EXEC : S_RD_RT;
      end
      S_RD_RT: begin
        reg_on  = 1'b1;
        a_d     = reg_data_out;
        raddr_d = WORD_SIZE'(rt_w);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Operands are forwarded straight from the read port in the cycle they arrive.
        sel_d = alu_sel(op_w, fn_w);
        if (is_addi_w) begin
          a_d  = reg_data_out;
          d1_d = reg_data_out;
          d2_d = sext16(ir_q[15:0]);
        end else begin
          d1_d = a_q;
          d2_d = reg_data_out;
        end
        cnt_d   = cnt_q + CNT_SIZE'(1);
        state_d = is_beq_w ? S_BR : S_WB;
      end
      S_WB: begin
        raddr_d    = WORD_SIZE'(dest_w);
        rdin_d     = r_q;
        reg_on     = (dest_w != 5'd0);
        reg_w      = (dest_w != 5'd0);
        pc_offset  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_BR: begin
        instr_done = 1'b1;
        if (z_q) begin
          load_pc = 1'b1;
          pcd_d   = pc_counter + WORD_SIZE'(4) + (sext16(ir_q[15:0]) << 2);
        end else begin
          pc_offset = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_1      = d1_d;
  assign data_2      = d2_d;
  assign sel         = sel_d;
  assign reg_addr    = raddr_d;
  assign reg_data_in = rdin_d;
  assign pc_data     = pcd_d;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized self-checking bench for mips_ctrl_fsm with register-file/ALU/PC environment
// and an instruction-level reference model.
module tb_mips_ctrl_fsm;
  localparam int W   = 32;
  localparam int OPW = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst, step, instr_req, instr_valid, reg_on, reg_w, alu_zero_flag;
  logic           pc_offset, load_pc, instr_done, halted;
  logic [W-1:0]   pc_counter, instr, reg_addr, reg_data_in, reg_data_out;
  logic [W-1:0]   data_1, data_2, alu_out, pc_data;
  logic [OPW-1:0] sel;
  logic [CW-1:0]  instr_count;

  always #5 clk = ~clk;

  mips_ctrl_fsm #(.WORD_SIZE(W), .OP_SIZE(OPW), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst(rst), .step(step), .pc_counter(pc_counter),
    .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr),
    .reg_on(reg_on), .reg_w(reg_w), .reg_addr(reg_addr), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .data_1(data_1), .data_2(data_2), .sel(sel),
    .alu_out(alu_out), .alu_zero_flag(alu_zero_flag), .pc_offset(pc_offset),
    .load_pc(load_pc), .pc_data(pc_data), .instr_done(instr_done),
    .instr_count(instr_count), .halted(halted)
  );

  // Environment: register file, PC register and ALU.
  logic [W-1:0] rf [32];
  logic         poke_en, pc_poke_en;
  logic [4:0]   poke_addr;
  logic [W-1:0] poke_val, pc_poke_val;

  always @(posedge clk) begin
    if (poke_en) rf[poke_addr] <= poke_val;
    else if (reg_on && reg_w) rf[reg_addr[4:0]] <= reg_data_in;
    if (reg_on && !reg_w) reg_data_out <= rf[reg_addr[4:0]];
    if (pc_poke_en) pc_counter <= pc_poke_val;
    else if (load_pc) pc_counter <= pc_data;
    else if (pc_offset) pc_counter <= pc_counter + 32'd4;
  end

  always_comb begin
    case (sel)
      4'd0:    alu_out = data_1 + data_2;
      4'd1:    alu_out = data_1 - data_2;
      4'd2:    alu_out = data_1 & data_2;
      4'd3:    alu_out = data_1 | data_2;
      4'd4:    alu_out = ($signed(data_1) < $signed(data_2)) ? 32'd1 : 32'd0;
      default: alu_out = '0;
    endcase
    alu_zero_flag = (alu_out == '0);
  end

  // Reference model state
  logic [W-1:0] mrf [32];
  logic [W-1:0] mpc;
  int           mcnt;
  int           n_chk, n_fail;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [W-1:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a[4:0]; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
    mrf[a] = v;
  endtask

  task automatic set_pc(input logic [W-1:0] v);
    @(negedge clk);
    pc_poke_en = 1'b1; pc_poke_val = v;
    @(negedge clk);
    pc_poke_en = 1'b0;
    mpc = v;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int stall);
    logic [5:0]   op, fn;
    logic [4:0]   rs, rt, rd, dest;
    logic [W-1:0] a, b, imm, res, exp_pc, wr_addr, wr_data, pcd;
    logic         wr_exp, taken, done, sent;
    int           cyc, req_cyc, rd_cyc, wr_cyc, off_cyc, ld_cyc, fetch_n, cnt_at_done;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = mrf[rs]; b = mrf[rt];
    imm = {{16{ins[15]}}, ins[15:0]};
    res = '0; dest = rd; wr_exp = 1'b0; taken = 1'b0; exp_pc = mpc + 32'd4;
    if (op == 6'h08) begin
      res = a + imm; dest = rt; wr_exp = (rt != 0);
    end else if (op == 6'h04) begin
      taken = (a == b);
      if (taken) exp_pc = mpc + 32'd4 + imm * 32'd4;
    end else begin
      case (fn)
        6'h20:   res = a + b;
        6'h22:   res = a - b;
        6'h24:   res = a & b;
        6'h25:   res = a | b;
        default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      wr_exp = (rd != 0);
    end

    @(negedge clk);
    step = 1'b1;
    cyc = 1; req_cyc = 0; rd_cyc = 0; wr_cyc = 0; off_cyc = 0; ld_cyc = 0; fetch_n = 0;
    cnt_at_done = 0; done = 1'b0; sent = 1'b0; wr_addr = '0; wr_data = '0; pcd = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      step = 1'b0;
      if (instr_req) req_cyc++;
      if (reg_on && !reg_w) rd_cyc++;
      if (reg_on && reg_w) begin wr_cyc++; wr_addr = reg_addr; wr_data = reg_data_in; end
      if (pc_offset) off_cyc++;
      if (load_pc) begin ld_cyc++; pcd = pc_data; end
      if (instr_done) begin done = 1'b1; cnt_at_done = int'(instr_count); end
      if (instr_req && !sent) begin
        if (fetch_n == stall) begin instr_valid = 1'b1; instr = ins; sent = 1'b1; end
        else begin instr_valid = 1'b0; instr = $urandom; end
        fetch_n++;
      end else begin
        // A stray valid with an illegal word must be ignored outside FETCH.
        instr_valid = ($urandom % 2) == 1;
        instr = 32'hFC00_0000;
      end
    end
    instr_valid = 1'b0;
    mcnt = (mcnt + 1) % (1 << CW);
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'((op == 6'h08 ? 5 : 6) + stall));
    chk("req_cycles", 32'(req_cyc), 32'(stall + 1));
    chk("reads", 32'(rd_cyc), (op == 6'h08) ? 32'd1 : 32'd2);
    chk("writes", 32'(wr_cyc), 32'(wr_exp));
    if (wr_exp) begin
      chk("wr_addr", wr_addr, 32'(dest));
      chk("wr_data", wr_data, res);
      mrf[dest] = res;
    end
    chk("pc_cmds", 32'(off_cyc + ld_cyc), 32'd1);
    chk("load_pc", 32'(ld_cyc), 32'(taken));
    if (taken) chk("pc_data", pcd, exp_pc);
    chk("count", 32'(cnt_at_done), 32'(mcnt));
    mpc = exp_pc;
    @(negedge clk);
    chk("pc", pc_counter, mpc);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_strobes"}, 32'({instr_req, reg_on, reg_w, pc_offset, load_pc, instr_done, halted}), 32'd0);
    chk({tag, "_data"}, data_1 | data_2 | reg_addr | reg_data_in | pc_data, 32'd0);
    chk({tag, "_sel_cnt"}, 32'({sel, instr_count}), 32'd0);
  endtask

  task automatic reset_in_exec(input logic [31:0] ins);
    logic [4:0] rd;
    int         strobes;
    rd = ins[15:11];
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; instr_valid = 1'b1; instr = ins;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("exec_d1", data_1, mrf[ins[25:21]]);
    chk("exec_d2", data_2, mrf[ins[20:16]]);
    rst = 1'b0;
    #1;
    check_cleared("rst_exec");
    strobes = 0;
    repeat (2) begin
      @(negedge clk);
      if (reg_w || pc_offset || load_pc || instr_done) strobes++;
    end
    rst = 1'b1;
    mcnt = 0;
    @(negedge clk);
    chk("rst_no_strobes", 32'(strobes), 32'd0);
    chk("rst_no_write", rf[rd], mrf[rd]);
    chk("rst_no_pc", pc_counter, mpc);
  endtask

  task automatic run_halt(input logic [31:0] ins);
    int strobes;
    @(negedge clk); step = 1'b1;
    @(negedge clk);
    chk("halt_req", 32'(instr_req), 32'd1);
    instr_valid = 1'b1; instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("halted", 32'(halted), 32'd1);
    strobes = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_req || reg_on || reg_w || pc_offset || load_pc || instr_done) strobes++;
      instr_valid = ($urandom % 2) == 1;
      instr = 32'h0022_1820;
    end
    instr_valid = 1'b0;
    chk("halt_strobes", 32'(strobes), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_pc", pc_counter, mpc);
    rst = 1'b0;
    #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b1; step = 1'b0;
    mcnt = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] w;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h24;
      3:       fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case ($urandom_range(0, 2))
      0:       w = {6'h00, rs, rt, rd, 5'd0, fn};
      1:       w = {6'h08, rs, rt, imm};
      default: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        w = {6'h04, rs, rt, imm};
      end
    endcase
    return w;
  endfunction

  initial begin
    n_chk = 0; n_fail = 0; mcnt = 0; mpc = '0;
    rst = 1'b0; step = 1'b0; instr_valid = 1'b0; instr = '0;
    poke_en = 1'b0; poke_addr = '0; poke_val = '0; pc_poke_en = 1'b0; pc_poke_val = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b1;
    set_pc(32'h0);
    poke(0, 32'h0);
    for (int i = 1; i < 32; i++) poke(i, $urandom);

    poke(1, 32'd5); poke(2, 32'd7);
    run_instr(32'h0022_1820, 0);
    chk("add_r3", rf[3], 32'd12);
    poke(1, 32'd3);
    run_instr(32'h2022_FFFE, 0);
    chk("addi_r2", rf[2], 32'd1);
    set_pc(32'h100); poke(1, 32'd9); poke(2, 32'd9);
    run_instr(32'h1022_FFFC, 0);
    chk("beq_taken_pc", pc_counter, 32'hF4);
    poke(2, 32'd8);
    run_instr(32'h1022_FFFC, 0);
    chk("beq_not_taken_pc", pc_counter, 32'hF8);
    run_instr(32'h0022_0020, 0);
    run_instr(32'h0022_1822, 5);

    set_pc($urandom & 32'hFFFF_FFFC);
    for (int n = 0; n < 40; n++) run_instr(rand_instr(), $urandom_range(0, 3));

    poke(1, 32'd11); poke(2, 32'd4);
    reset_in_exec(32'h0022_1820);
    run_instr(32'h0022_1820, 1);
    run_halt(32'hFC00_0000);
    run_halt(32'h0022_1821);
    run_instr(rand_instr(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
